regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- 32-entry x 32-bit register file with two asynchronous read ports and one synchronous write port.
- Sits directly upstream of the 32-input x 32-bit read multiplexers. It holds the 32 register words that those muxes select from.
- The write-address decoder and per-register enables are internal; register 0 is hardwired to zero.
- Consumers are the CPU decode/execute stage (read) and write-back (write).

Parameters:
- WIDTH, 32, data width of every register and of every data port.
- DEPTH_LOG2, 5, address width; the register count is 2**DEPTH_LOG2 (fixed at 32 for this design).
- BYPASS, 0, when 1 a read of the register being written this cycle returns write_data combinationally.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears every register while high.
- read_addr1  input  5  register index for read port 1.
- read_addr2  input  5  register index for read port 2.
- read_data1  output  32  contents of register read_addr1.
- read_data2  output  32  contents of register read_addr2.
- write_addr  input  5  register index to write.
- write_data  input  32  value to write.
- reg_write  input  1  write enable, sampled on rising clk.

Behaviour:
- Reset:
  - While reset=1, all 32 registers read 0 immediately, regardless of clk.
  - read_data1/2 therefore read 0 throughout reset.
  - Writes are ignored while reset=1.
  - Reset deasserting mid-cycle: the first write takes effect on the next rising edge with reset=0.
- Write:
  - On rising clk with reset=0 and reg_write=1, register[write_addr] <= write_data.
  - Update is visible on the read ports after that edge (write latency 1 cycle).
  - Address decoding: the 5-bit write_addr is decoded one-hot, ANDed with reg_write, and gates 32 enabled registers. Exactly one enable is high when reg_write=1, none when reg_write=0.
- Register 0:
  - Never written. Enable 0 is tied off.
  - Always reads 0 on both ports, including when BYPASS=1 and write_addr=0.
- Read:
  - Purely combinational from current register state; no clock latency.
  - Both ports may address the same register; both return the same value.
- Read/write same register, same cycle:
  - BYPASS=0: the read returns the old value until the edge, then the new value.
  - BYPASS=1: the read returns write_data during the cycle (unless the address is 0). Applies to each port independently.
- No X propagation: every register has a defined value from reset onward.
- Back-to-back writes to the same register on consecutive edges: the last write wins and each is visible for one cycle.

Decomposition:
- Shared `include header holds the REG_WIDTH (32) and REG_ADDR_BITS (5) constants and the ZERO_REG index (0). Both this block and the mux blocks use it.
- Sub-module register32:
  - WIDTH-bit flop with enable and async active-high reset.
  - Instantiated 31 times (indices 1..31); index 0 is a constant zero.
- The decoder is written inline as a one-hot shift of reg_write by write_addr.
- Read selection uses two instances of the existing 32-input x 32-bit mux block. The BYPASS compare/select sits after each mux output.

Test Plan:
- Reset:
  - Stimulus: preload r5=32'hDEADBEEF, then assert reset asynchronously between edges with read_addr1=5.
  - Response: read_data1=0 before the next clk edge; all registers read 0 after.
- Write/readback:
  - Stimulus: write r1..r31 with value 32'h1000+i on successive edges, then sweep both read ports.
  - Response: read_data1 = read_data2 = 32'h1000+i for each i, and 0 for i=0.
- Zero register:
  - Stimulus: reg_write=1, write_addr=0, write_data=32'hFFFFFFFF, both BYPASS settings.
  - Response: read_data1 with read_addr1=0 stays 0 before and after the edge.
- Write enable low:
  - Stimulus: r9=32'h00000FFF, then reg_write=0, write_addr=9, write_data=32'h12345678 for 3 edges.
  - Response: r9 still reads 32'h00000FFF.
- Same-cycle read/write, r20=20:
  - Stimulus: write_data=99 to r20 while read_addr1=20.
  - Response: BYPASS=0 gives 20 before the edge and 99 after; BYPASS=1 gives 99 immediately.
- Dual-port independence:
  - Stimulus: r3=3, r31=31, read_addr1=3, read_addr2=31, then swap the addresses.
  - Response: outputs swap to 31 and 3 with no clock edge.

Source files
------------

// File: rtl/regfile_2r1w_pkg.sv
// Shared constants, types and helpers for the 32x32 two-read/one-write register file
// and the read multiplexers that select from it.
package regfile_2r1w_pkg;

  localparam int unsigned REG_WIDTH     = 32;
  localparam int unsigned REG_ADDR_BITS = 5;
  localparam int unsigned REG_COUNT     = 1 << REG_ADDR_BITS;
  localparam int unsigned ZERO_REG      = 0;

  typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]     reg_data_t;

  // A read hits the in-flight write when addresses match, except for the zero register.
  function automatic logic bypass_hit(input logic      we,
                                      input reg_addr_t rd_addr,
                                      input reg_addr_t wr_addr);
    return we && (rd_addr == wr_addr) && (rd_addr != REG_ADDR_BITS'(ZERO_REG));
  endfunction

endpackage

// File: rtl/regfile_2r1w_if.sv
// Read/write bus between the register file and its decode and write-back clients.
interface regfile_2r1w_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 5
);

  logic [ADDR_BITS-1:0] read_addr1;
  logic [ADDR_BITS-1:0] read_addr2;
  logic [WIDTH-1:0]     read_data1;
  logic [WIDTH-1:0]     read_data2;
  logic [ADDR_BITS-1:0] write_addr;
  logic [WIDTH-1:0]     write_data;
  logic                 reg_write;

  // Client side: issues addresses and write data, consumes read data.
  modport master (
    output read_addr1, read_addr2, write_addr, write_data, reg_write,
    input  read_data1, read_data2
  );

  // Register file side.
  modport slave (
    input  read_addr1, read_addr2, write_addr, write_data, reg_write,
    output read_data1, read_data2
  );

endinterface

// File: rtl/regfile_2r1w_mux32.sv
// 2**SEL_BITS-input word multiplexer used for each register file read port.
module regfile_2r1w_mux32 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SEL_BITS = 5
) (
  input  logic [(1<<SEL_BITS)-1:0][WIDTH-1:0] data_i,
  input  logic [SEL_BITS-1:0]                 sel_i,
  output logic [WIDTH-1:0]                    data_o
);

  assign data_o = data_i[sel_i];

endmodule

// File: rtl/regfile_2r1w_register32.sv
// Enabled WIDTH-bit register with asynchronous active-high clear; one per writable entry.
module register32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write port,
// register 0 hardwired to zero, optional same-cycle write-to-read bypass.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned WIDTH      = REG_WIDTH,
  parameter int unsigned DEPTH_LOG2 = REG_ADDR_BITS,
  parameter bit          BYPASS     = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  regfile_2r1w_if.slave  bus
);

  localparam int unsigned NREGS = 1 << DEPTH_LOG2;

  logic [NREGS-1:1]            wr_en;
  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [WIDTH-1:0]            mux1_data;
  logic [WIDTH-1:0]            mux2_data;
  logic                        hit1;
  logic                        hit2;

  // One-hot write decode; bit 0 is dropped so the zero register has no enable.
  assign wr_en = (NREGS-1)'((NREGS'(bus.reg_write) << bus.write_addr) >> 1);

  assign regs[ZERO_REG] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    register32 #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk  (clk),
      .rst  (reset),
      .en_i (wr_en[i]),
      .d_i  (bus.write_data),
      .q_o  (regs[i])
    );
  end

  regfile_2r1w_mux32 #(
    .WIDTH    (WIDTH),
    .SEL_BITS (DEPTH_LOG2)
  ) u_mux1 (
    .data_i (regs),
    .sel_i  (bus.read_addr1),
    .data_o (mux1_data)
  );

  regfile_2r1w_mux32 #(
    .WIDTH    (WIDTH),
    .SEL_BITS (DEPTH_LOG2)
  ) u_mux2 (
    .data_i (regs),
    .sel_i  (bus.read_addr2),
    .data_o (mux2_data)
  );

  // Bypass is suppressed during reset so both ports read zero throughout it.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (BYPASS && !reset) begin
      hit1 = bypass_hit(bus.reg_write, bus.read_addr1, bus.write_addr);
      hit2 = bypass_hit(bus.reg_write, bus.read_addr2, bus.write_addr);
    end
    bus.read_data1 = hit1 ? bus.write_data : mux1_data;
    bus.read_data2 = hit2 ? bus.write_data : mux2_data;
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: one copy without and one with bypass, driven identically
// and compared against an array model of the register contents.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic        we;

  logic [31:0] mdl [32];
  logic [31:0] rd [2][2];
  int          checks;
  int          errors;

  regfile_2r1w_if #(.WIDTH(32), .ADDR_BITS(5)) if0 ();
  regfile_2r1w_if #(.WIDTH(32), .ADDR_BITS(5)) if1 ();

  assign if0.read_addr1 = ra1;
  assign if0.read_addr2 = ra2;
  assign if0.write_addr = wa;
  assign if0.write_data = wd;
  assign if0.reg_write  = we;
  assign if1.read_addr1 = ra1;
  assign if1.read_addr2 = ra2;
  assign if1.write_addr = wa;
  assign if1.write_data = wd;
  assign if1.reg_write  = we;

  assign rd[0][0] = if0.read_data1;
  assign rd[0][1] = if0.read_data2;
  assign rd[1][0] = if1.read_data1;
  assign rd[1][1] = if1.read_data2;

  regfile_2r1w #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1'b0)) u_dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (if0.slave)
  );

  regfile_2r1w #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1'b1)) u_dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value for a copy (b=1 means bypass enabled) at address a right now.
  function automatic logic [31:0] exp_read(input int b, input logic [4:0] a);
    if (rst || a == 5'd0) return 32'd0;
    if (b == 1 && we && a == wa) return wd;
    return mdl[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst && we && wa != 5'd0) mdl[wa] = wd;
    #1;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
    we = 1'b1; wa = a; wd = v;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    set_rst(1'b1);
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd0;
    tick();
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rd[b][p] !== 32'd0) begin
          errors++;
          $display("FAIL reset_hold bypass=%0d port=%0d got=%h exp=%h", b, p + 1, rd[b][p], 32'd0);
        end
      end
    #2 set_rst(1'b0);
    #1;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (rd[b][0] !== exp_read(b, ra1)) begin
        errors++;
        $display("FAIL reset_release_pre bypass=%0d got=%h exp=%h", b, rd[b][0], exp_read(b, ra1));
      end
    end
    tick();
    we = 1'b0;
    #1;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (rd[b][0] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL reset_first_write bypass=%0d got=%h exp=%h", b, rd[b][0], 32'hDEADBEEF);
      end
    end
    #2 set_rst(1'b1);
    #1;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (rd[b][0] !== 32'd0) begin
        errors++;
        $display("FAIL reset_async bypass=%0d got=%h exp=%h", b, rd[b][0], 32'd0);
      end
    end
    tick();
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #1;
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < 2; p++) begin
          checks++;
          if (rd[b][p] !== 32'd0) begin
            errors++;
            $display("FAIL reset_sweep bypass=%0d port=%0d addr=%0d got=%h exp=%h",
                     b, p + 1, a, rd[b][p], 32'd0);
          end
        end
    end
    set_rst(1'b0);
    tick();
  endtask

  task automatic test_write_readback();
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'h1000 + 32'(i));
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      #1;
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < 2; p++) begin
          checks++;
          if (rd[b][p] !== ((i == 0) ? 32'd0 : 32'h1000 + 32'(i))) begin
            errors++;
            $display("FAIL readback bypass=%0d port=%0d addr=%0d got=%h exp=%h",
                     b, p + 1, i, rd[b][p], (i == 0) ? 32'd0 : 32'h1000 + 32'(i));
          end
        end
    end
  endtask

  task automatic test_zero_reg();
    ra1 = 5'd0; ra2 = 5'd0; we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    #1;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (rd[b][0] !== 32'd0) begin
        errors++;
        $display("FAIL zero_reg_pre bypass=%0d got=%h exp=%h", b, rd[b][0], 32'd0);
      end
    end
    tick();
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rd[b][p] !== 32'd0) begin
          errors++;
          $display("FAIL zero_reg_post bypass=%0d port=%0d got=%h exp=%h", b, p + 1, rd[b][p], 32'd0);
        end
      end
    we = 1'b0;
  endtask

  task automatic test_we_low();
    write_reg(5'd9, 32'h00000FFF);
    we = 1'b0; wa = 5'd9; wd = 32'h12345678; ra1 = 5'd9; ra2 = 5'd9;
    for (int n = 0; n < 3; n++) begin
      tick();
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (rd[b][0] !== 32'h00000FFF) begin
          errors++;
          $display("FAIL we_low edge=%0d bypass=%0d got=%h exp=%h", n, b, rd[b][0], 32'h00000FFF);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    write_reg(5'd20, 32'd20);
    we = 1'b1; wa = 5'd20; wd = 32'd99; ra1 = 5'd20; ra2 = 5'd19;
    #1;
    checks++;
    if (rd[0][0] !== 32'd20) begin
      errors++;
      $display("FAIL same_cycle_nobypass_pre got=%0d exp=%0d", rd[0][0], 20);
    end
    checks++;
    if (rd[1][0] !== 32'd99) begin
      errors++;
      $display("FAIL same_cycle_bypass_pre got=%0d exp=%0d", rd[1][0], 99);
    end
    checks++;
    if (rd[1][1] !== 32'h1000 + 32'd19) begin
      errors++;
      $display("FAIL same_cycle_bypass_other_port got=%h exp=%h", rd[1][1], 32'h1000 + 32'd19);
    end
    tick();
    we = 1'b0;
    #1;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (rd[b][0] !== 32'd99) begin
        errors++;
        $display("FAIL same_cycle_post bypass=%0d got=%0d exp=%0d", b, rd[b][0], 99);
      end
    end
  endtask

  task automatic test_dual_port();
    write_reg(5'd3, 32'd3);
    write_reg(5'd31, 32'd31);
    ra1 = 5'd3; ra2 = 5'd31;
    #1;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (rd[b][0] !== 32'd3 || rd[b][1] !== 32'd31) begin
        errors++;
        $display("FAIL dual_port bypass=%0d got=%0d,%0d exp=3,31", b, rd[b][0], rd[b][1]);
      end
    end
    #2 ra1 = 5'd31; ra2 = 5'd3;
    #1;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (rd[b][0] !== 32'd31 || rd[b][1] !== 32'd3) begin
        errors++;
        $display("FAIL dual_port_swap bypass=%0d got=%0d,%0d exp=31,3", b, rd[b][0], rd[b][1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    ra1 = 5'd7; ra2 = 5'd7;
    for (int n = 0; n < 3; n++) vals[n] = $urandom;
    for (int n = 0; n < 3; n++) begin
      we = 1'b1; wa = 5'd7; wd = vals[n];
      tick();
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (rd[b][1] !== vals[n]) begin
          errors++;
          $display("FAIL back_to_back n=%0d bypass=%0d got=%h exp=%h", n, b, rd[b][1], vals[n]);
        end
      end
    end
    we = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 300; n++) begin
      ra1 = 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      wa  = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
      wd  = $urandom;
      we  = 1'($urandom_range(0, 1));
      #1;
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < 2; p++) begin
          e = exp_read(b, (p == 0) ? ra1 : ra2);
          checks++;
          if (rd[b][p] !== e) begin
            errors++;
            $display("FAIL random n=%0d bypass=%0d port=%0d got=%h exp=%h", n, b, p + 1, rd[b][p], e);
          end
        end
      tick();
    end
    we = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    rst = 1'b1; ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0;
    test_reset();
    test_write_readback();
    test_zero_reg();
    test_we_low();
    test_same_cycle();
    test_dual_port();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
